piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parameterised parallel-in/serial-out shift engine for board I/O (switches -> LEDs/serial pins).
//  Accepts WIDTH-bit words via a valid/ready handshake into a 1-deep holding buffer.
//  Shifts each word out one bit per internal tick, MSB- or LSB-first chosen per word.
//  Back-to-back words stream with no gap. The live shift register is exposed for LED display.
// PARAMETERS
//  WIDTH     8    word width in bits (>=2)
//  DIV       5    clk cycles per shifted bit (>=1; 1 = shift every cycle)
//  FILL_BIT  1'b0 value shifted into the vacated end of the shift register
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  load_data  in   WIDTH  parallel word to serialise
//  load_lsb   in   1      1 = this word goes out LSB-first, 0 = MSB-first; sampled with load_data
//  load_valid in   1      producer has a word
//  load_ready out  1      holding buffer empty; a word is accepted when load_valid&&load_ready
//  ser_out    out  1      current serial bit (head of shift register)
//  ser_valid  out  1      ser_out carries a data bit
//  word_done  out  1      1-cycle pulse on the cycle after the last bit of a word finishes
//  busy       out  1      state==SHIFT or holding buffer full
//  par_view   out  WIDTH  live shift register contents (drive LEDs)
// BEHAVIOUR
//  Reset (rst=1 at a posedge): state=IDLE, shift_reg=0, hold empty, tick counter=0, bit_cnt=0.
//   Outputs: ser_out=0, ser_valid=0, word_done=0, busy=0, par_view=0, load_ready=0 while rst is high.
//   load_ready=1 from the first cycle after rst deasserts. Reset mid-word discards the word and the buffer.
//  load_ready = !hold_valid (registered; no combinational path from load_valid).
//  Accept: hold_data<=load_data, hold_lsb<=load_lsb, hold_valid<=1.
//  States IDLE, SHIFT:
//   IDLE & hold_valid: shift_reg<=hold_data, lsb_mode<=hold_lsb, hold_valid<=0, bit_cnt<=0,
//    tick counter<=0, ->SHIFT.
//   SHIFT: tick when counter==DIV-1; the counter wraps to 0. Each bit is therefore held exactly DIV cycles.
//    Tick with bit_cnt<WIDTH-1: shift one place; bit_cnt++.
//     MSB-first: {sr[W-2:0],FILL_BIT}. LSB-first: {FILL_BIT,sr[W-1:1]}.
//    Tick with bit_cnt==WIDTH-1: word_done<=1.
//     If hold_valid: reload from hold as in IDLE, stay in SHIFT (zero-gap streaming).
//     Otherwise: ->IDLE, shift_reg keeps its last shifted value.
//  ser_out = lsb_mode ? sr[0] : sr[WIDTH-1]; ser_valid = (state==SHIFT).
//  Latency: accept at edge t -> hold_valid at t+1 -> SHIFT with bit0 on ser_out at t+2.
//   A word occupies exactly WIDTH*DIV cycles of ser_valid.
//  Accept in the same cycle as a reload from hold: the reload empties hold in that cycle, but
//   load_ready is still 0 (registered). The next word is accepted one cycle later.
//  load_lsb affects only its own word; changing load_lsb mid-word has no effect.
//  load_valid while load_ready=0: ignored. The producer holds its data until accepted.
//  DIV=1: tick is every cycle in SHIFT; the counter is constant 0.
// STRUCTURE
//  piso_defs.vh: localparams ST_IDLE=1'b0, ST_SHIFT=1'b1; default WIDTH/DIV. Shared with future SIPO/PIPO blocks.
//  Sub-module tick_gen #(DIV): inputs clk, rst, clear; output tick. Replaces the ad-hoc clock dividers.
//   All logic stays on clk; no derived clocks.
//  Top level holds the holding buffer, FSM, shift_reg and bit_cnt ($clog2(WIDTH) bits).
// TESTING (WIDTH=8, DIV=3 unless stated)
//  1. Reset: hold rst 2 cycles -> all outputs 0, load_ready=0. Release -> load_ready=1 next cycle.
//  2. MSB-first: 8'hA5, lsb=0 -> ser_out 1,0,1,0,0,1,0,1, each for 3 cycles; ser_valid 24 cycles.
//     word_done pulses once; par_view ends 8'h00.
//  3. LSB-first: 8'hA5, lsb=1 -> ser_out 1,0,1,0,0,1,0,1 (LSB first), 24 cycles. Repeat with
//     FILL_BIT=1 -> par_view ends 8'hFF.
//  4. Streaming: send 8'hF0 then 8'h0F with load_valid held high -> the second word is accepted while
//     the first shifts. 48 contiguous ser_valid cycles, no gap; word_done at 24 and 48.
//  5. Backpressure: hold full + SHIFT, assert load_valid with 8'h33 -> not accepted, load_ready=0.
//     Accepted only after the reload; data is not lost or duplicated.
//  6. Mid-word reset: rst at bit 3 of 8'hC3 -> next cycle ser_valid=0, par_view=0, busy=0.
//     A subsequent 8'h81 serialises cleanly. Also run DIV=1: 8'h81 shifts in 8 cycles.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel/serial shift blocks: FSM encoding,
// default geometry and a counter-width helper.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 5;

  // A counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_tick_gen.sv
// Free-running divider on clk: tick is high for one cycle out of every DIV.
// clear holds the count at zero so the first period after release is full length.
module tick_gen
  import piso_serializer_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 LAST is zero, so cnt never leaves 0 and tick is constant high.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a 1-deep holding buffer, per-word bit
// order and zero-gap streaming; the live shift register drives par_view.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter int   DIV      = DEFAULT_DIV,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_lsb,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic [WIDTH-1:0] par_view
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_lsb;
  logic             hold_valid;
  logic [WIDTH-1:0] shift_reg;
  logic             lsb_mode;
  logic [BW-1:0]    bit_cnt;
  logic             out_of_reset;
  logic             done_q;
  logic             tick;
  logic             shift_tick;
  logic             last_tick;
  logic             load_from_hold;
  logic             accept;

  // Handshake: a word transfers on any posedge where load_valid && load_ready.
  // load_ready depends only on registers (never on load_valid); the producer
  // keeps load_data/load_lsb stable until the transfer happens.
  assign load_ready = out_of_reset && !hold_valid;
  assign accept     = load_valid && load_ready;

  assign shift_tick     = (state == ST_SHIFT) && tick;
  assign last_tick      = shift_tick && (bit_cnt == LAST_BIT);
  assign load_from_hold = hold_valid && ((state == ST_IDLE) || last_tick);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ST_SHIFT),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // accept and load_from_hold are mutually exclusive: one needs hold empty,
  // the other hold full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_lsb   <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= load_data;
      hold_lsb   <= load_lsb;
    end else if (load_from_hold) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hold_valid) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_tick && !hold_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The final tick of a word also shifts, so an idle register shows only
  // fill bits once the word has fully left.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      lsb_mode  <= 1'b0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_tick;
      if (load_from_hold) begin
        shift_reg <= hold_data;
        lsb_mode  <= hold_lsb;
        bit_cnt   <= '0;
      end else if (shift_tick) begin
        shift_reg <= lsb_mode ? {FILL_BIT, shift_reg[WIDTH-1:1]}
                              : {shift_reg[WIDTH-2:0], FILL_BIT};
        if (!last_tick) begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    ser_valid = (state == ST_SHIFT);
    busy      = (state == ST_SHIFT) || hold_valid;
    ser_out   = lsb_mode ? shift_reg[0] : shift_reg[WIDTH-1];
    word_done = done_q;
    par_view  = shift_reg;
  end

endmodule
